// File: rtl/spram_pkg.sv
// Shared encodings for the byte-enable single-port RAM: write modes, clear FSM states, lane parity.
package spram_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_st_e;

  // Even parity for one byte lane; callers zero-extend the lane to 64 bits.
  function automatic logic par_lane(input logic [63:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/spram_clr_fsm.sv
// Post-reset clear sequencer: walks every word address once, holding busy until done.
module spram_clr_fsm
  import spram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int CLR_ON_RST = 1
)(
  input  logic              clka,
  input  logic              rsta_n,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_clr_addr
);

  clr_st_e           r_state, w_nxt;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Counter wraps to 0 on the last word, so a later reset restarts cleanly.
  always_comb begin
    w_nxt = r_state;
    if (r_state == ST_CLEAR && (&r_cnt)) w_nxt = ST_READY;
  end

  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/spram_be.sv
// Single-port RAM with byte write enables, selectable write mode and 1/2-cycle read latency.
// Optional lane parity storage and checking when SPRAM_PARITY_EN is defined.
module spram_be
  import spram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int COL_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int WRITE_MODE = WM_READ_FIRST,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1,
  localparam int NB_COL    = DATA_W / COL_W
)(
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              ena,
  input  logic [NB_COL-1:0] wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              dvalid,
  output logic              busy,
  output logic              perr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_busy, w_acc, w_wr, w_v1;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [DATA_W-1:0] w_old, w_merged, w_rd;

  spram_clr_fsm #(.ADDR_W(ADDR_W), .CLR_ON_RST(CLR_ON_RST)) u_clr (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .o_busy    (w_busy),
    .o_clr_addr(w_clr_addr)
  );

  assign busy  = w_busy;
  assign w_acc = ena & ~w_busy;
  assign w_wr  = w_acc & (|wea);
  assign w_old = r_mem[addra];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB_COL; i++)
      if (wea[i]) w_merged[i*COL_W +: COL_W] = dina[i*COL_W +: COL_W];
  end

  assign w_rd = (WRITE_MODE == WM_WRITE_FIRST && w_wr) ? w_merged : w_old;
  assign w_v1 = w_acc & ~(WRITE_MODE == WM_NO_CHANGE && w_wr);

  // Array has no reset; the clear sequencer owns the write port while busy.
  always_ff @(posedge clka) begin
    if (w_busy) r_mem[w_clr_addr] <= '0;
    else if (w_wr)
      for (int i = 0; i < NB_COL; i++)
        if (wea[i]) r_mem[addra][i*COL_W +: COL_W] <= dina[i*COL_W +: COL_W];
  end

  logic [RD_LAT:1]             r_vld_pipe;
  logic [RD_LAT:1][DATA_W-1:0] r_dpipe;

  // Data stages load only on valid so douta holds between accesses.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_vld_pipe <= '0;
      r_dpipe    <= '0;
    end else begin
      r_vld_pipe[1] <= w_v1;
      if (w_v1) r_dpipe[1] <= w_rd;
      for (int k = 2; k <= RD_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dpipe[k] <= r_dpipe[k-1];
      end
    end
  end

  assign douta  = r_dpipe[RD_LAT];
  assign dvalid = r_vld_pipe[RD_LAT];

`ifdef SPRAM_PARITY_EN
  logic [NB_COL-1:0] r_par [DEPTH];
  logic [NB_COL-1:0] w_par_new, w_par_rd, w_par_calc;
  logic              w_perr_rd;
  logic [RD_LAT:1]   r_ppipe;

  always_comb begin
    w_par_new = r_par[addra];
    for (int i = 0; i < NB_COL; i++)
      if (wea[i]) w_par_new[i] = par_lane(64'(dina[i*COL_W +: COL_W]));
    w_par_rd = (WRITE_MODE == WM_WRITE_FIRST && w_wr) ? w_par_new : r_par[addra];
    for (int i = 0; i < NB_COL; i++)
      w_par_calc[i] = par_lane(64'(w_rd[i*COL_W +: COL_W]));
    w_perr_rd = |(w_par_calc ^ w_par_rd);
  end

  always_ff @(posedge clka) begin
    if (w_busy) r_par[w_clr_addr] <= '0;
    else if (w_wr)
      for (int i = 0; i < NB_COL; i++)
        if (wea[i]) r_par[addra][i] <= w_par_new[i];
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) r_ppipe <= '0;
    else begin
      r_ppipe[1] <= w_v1 & w_perr_rd;
      for (int k = 2; k <= RD_LAT; k++) r_ppipe[k] <= r_ppipe[k-1];
    end
  end

  assign perr = r_ppipe[RD_LAT];
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_spram_be.sv
// Directed bench: three spram_be instances (READ_FIRST/lat1, WRITE_FIRST/lat2, NO_CHANGE/lat1) on shared inputs.
module tb_spram_be;

  logic        clka = 1'b0;
  logic        rsta_n, ena;
  logic [3:0]  wea, addra;
  logic [31:0] dina;
  logic [31:0] douta_rf, douta_wf, douta_nc;
  logic        dvalid_rf, dvalid_wf, dvalid_nc;
  logic        busy_rf, busy_wf, busy_nc;
  logic        perr_rf, perr_wf, perr_nc;

  int checks = 0;
  int errors = 0;

  // values captured by do_read
  logic        c_rf_v, c_nc_v, c_wf_early, c_wf_v, c_rf_p, c_wf_p;
  logic [31:0] c_rf_d, c_nc_d, c_wf_d;

  always #5 clka = ~clka;

  spram_be #(.ADDR_W(4), .WRITE_MODE(0), .RD_LAT(1)) u_rf (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_rf), .dvalid(dvalid_rf), .busy(busy_rf), .perr(perr_rf));
  spram_be #(.ADDR_W(4), .WRITE_MODE(1), .RD_LAT(2)) u_wf (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_wf), .dvalid(dvalid_wf), .busy(busy_wf), .perr(perr_wf));
  spram_be #(.ADDR_W(4), .WRITE_MODE(2), .RD_LAT(1)) u_nc (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_nc), .dvalid(dvalid_nc), .busy(busy_nc), .perr(perr_nc));

  task automatic cyc;
    @(posedge clka);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    ena = 1'b1; wea = we; addra = a; dina = d;
    cyc;
    ena = 1'b0; wea = '0;
    cyc;
    cyc;
  endtask

  task automatic do_read(input logic [3:0] a);
    ena = 1'b1; wea = '0; addra = a;
    cyc;
    ena = 1'b0;
    c_rf_v = dvalid_rf; c_rf_d = douta_rf; c_rf_p = perr_rf;
    c_nc_v = dvalid_nc; c_nc_d = douta_nc; c_wf_early = dvalid_wf;
    cyc;
    c_wf_v = dvalid_wf; c_wf_d = douta_wf; c_wf_p = perr_wf;
  endtask

  task automatic test_reset;
    int nb;
    rsta_n = 1'b0; ena = 1'b0; wea = '0; addra = '0; dina = '0;
    repeat (3) cyc;
    checks++;
    if ({busy_rf, busy_wf, busy_nc} !== 3'b111 || {dvalid_rf, dvalid_wf, dvalid_nc} !== 3'b000 ||
        {douta_rf, douta_wf, douta_nc} !== 96'h0 || {perr_rf, perr_wf, perr_nc} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state busy=%b%b%b dvalid=%b%b%b douta=%h/%h/%h exp busy=111 dvalid=000 douta=0",
               busy_rf, busy_wf, busy_nc, dvalid_rf, dvalid_wf, dvalid_nc, douta_rf, douta_wf, douta_nc);
    end
    rsta_n = 1'b1;
    nb = 0;
    while (busy_rf === 1'b1 && nb < 100) begin
      cyc;
      nb++;
    end
    checks++;
    if (nb != 16 || busy_wf !== 1'b0 || busy_nc !== 1'b0) begin
      errors++;
      $display("FAIL clear_len busy_cycles=%0d busy_wf=%b busy_nc=%b exp 16/0/0", nb, busy_wf, busy_nc);
    end
  endtask

  task automatic test_clear_read;
    logic erf, ewf;
    for (int i = 0; i <= 16; i++) begin
      ena = (i < 16); wea = '0; addra = i[3:0];
      cyc;
      erf = (i < 16);
      ewf = (i >= 1);
      checks++;
      if (dvalid_rf !== erf || douta_rf !== 32'h0 || dvalid_nc !== erf || douta_nc !== 32'h0 ||
          dvalid_wf !== ewf || douta_wf !== 32'h0) begin
        errors++;
        $display("FAIL clear_read step=%0d rf=%b/%h nc=%b/%h wf=%b/%h exp rf/nc=%b/0 wf=%b/0",
                 i, dvalid_rf, douta_rf, dvalid_nc, douta_nc, dvalid_wf, douta_wf, erf, ewf);
      end
    end
    ena = 1'b0;
  endtask

  task automatic test_full_write;
    do_write(4'h3, 32'h5555_5555, 4'hF);
    do_read(4'h3);
    checks++;
    if (c_rf_v !== 1'b1 || c_rf_d !== 32'h5555_5555 || c_nc_v !== 1'b1 || c_nc_d !== 32'h5555_5555) begin
      errors++;
      $display("FAIL full_wr_lat1 rf=%b/%h nc=%b/%h exp 1/55555555", c_rf_v, c_rf_d, c_nc_v, c_nc_d);
    end
    checks++;
    if (c_wf_early !== 1'b0 || c_wf_v !== 1'b1 || c_wf_d !== 32'h5555_5555) begin
      errors++;
      $display("FAIL full_wr_lat2 early=%b v=%b d=%h exp 0/1/55555555", c_wf_early, c_wf_v, c_wf_d);
    end
  endtask

  task automatic test_byte_enable;
    do_write(4'h3, 32'hAABB_CCDD, 4'b0101);
    do_read(4'h3);
    checks++;
    if (c_rf_v !== 1'b1 || c_rf_d !== 32'h55BB_55DD || c_nc_d !== 32'h55BB_55DD ||
        c_wf_v !== 1'b1 || c_wf_d !== 32'h55BB_55DD) begin
      errors++;
      $display("FAIL byte_en rf=%h nc=%h wf=%h exp 55bb55dd", c_rf_d, c_nc_d, c_wf_d);
    end
  endtask

  task automatic test_write_modes;
    do_write(4'h5, 32'hFFFF_0000, 4'hF);
    ena = 1'b1; wea = 4'hF; addra = 4'h5; dina = 32'h1234_5678;
    cyc;
    checks++;
    if (dvalid_rf !== 1'b1 || douta_rf !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL read_first got %b/%h exp 1/ffff0000", dvalid_rf, douta_rf);
    end
    checks++;
    if (dvalid_nc !== 1'b0 || douta_nc !== 32'h55BB_55DD) begin
      errors++;
      $display("FAIL no_change got %b/%h exp 0/55bb55dd", dvalid_nc, douta_nc);
    end
    wea = '0;
    cyc;
    checks++;
    if (dvalid_wf !== 1'b1 || douta_wf !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_first got %b/%h exp 1/12345678", dvalid_wf, douta_wf);
    end
    checks++;
    if (dvalid_rf !== 1'b1 || douta_rf !== 32'h1234_5678 || dvalid_nc !== 1'b1 || douta_nc !== 32'h1234_5678) begin
      errors++;
      $display("FAIL raw_next rf=%b/%h nc=%b/%h exp 1/12345678", dvalid_rf, douta_rf, dvalid_nc, douta_nc);
    end
    ena = 1'b0;
    cyc;
    checks++;
    if (dvalid_rf !== 1'b0 || douta_rf !== 32'h1234_5678 || dvalid_wf !== 1'b1 || douta_wf !== 32'h1234_5678) begin
      errors++;
      $display("FAIL hold rf=%b/%h wf=%b/%h exp rf 0/12345678 wf 1/12345678", dvalid_rf, douta_rf, dvalid_wf, douta_wf);
    end
    cyc;
  endtask

  task automatic test_reset_mid_clear;
    int  nb;
    logic sawv;
    do_write(4'h2, 32'h0BAD_F00D, 4'hF);
    rsta_n = 1'b0; #2; rsta_n = 1'b1;
    repeat (7) cyc;
    rsta_n = 1'b0; #2; rsta_n = 1'b1;
    ena = 1'b1; wea = 4'hF; addra = 4'h2; dina = 32'hDEAD_BEEF;
    nb = 0;
    sawv = 1'b0;
    while (busy_rf === 1'b1 && nb < 100) begin
      cyc;
      nb++;
      if (dvalid_rf === 1'b1 || dvalid_wf === 1'b1 || dvalid_nc === 1'b1) sawv = 1'b1;
    end
    ena = 1'b0; wea = '0;
    checks++;
    if (nb != 16 || sawv !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear busy_cycles=%0d dvalid_seen=%b exp 16/0", nb, sawv);
    end
    do_read(4'h2);
    checks++;
    if (c_rf_v !== 1'b1 || c_rf_d !== 32'h0 || c_nc_d !== 32'h0 || c_wf_v !== 1'b1 || c_wf_d !== 32'h0) begin
      errors++;
      $display("FAIL clr_addr2 rf=%b/%h nc=%h wf=%b/%h exp 0", c_rf_v, c_rf_d, c_nc_d, c_wf_v, c_wf_d);
    end
    do_read(4'h5);
    checks++;
    if (c_rf_d !== 32'h0 || c_wf_d !== 32'h0) begin
      errors++;
      $display("FAIL clr_addr5 rf=%h wf=%h exp 0", c_rf_d, c_wf_d);
    end
  endtask

`ifdef SPRAM_PARITY_EN
  task automatic test_parity;
    do_write(4'h3, 32'h5555_5555, 4'hF);
    do_read(4'h3);
    checks++;
    if (c_rf_v !== 1'b1 || c_rf_p !== 1'b0 || c_wf_p !== 1'b0) begin
      errors++;
      $display("FAIL parity_clean perr rf=%b wf=%b exp 0", c_rf_p, c_wf_p);
    end
    u_rf.r_mem[3][0] = ~u_rf.r_mem[3][0];
    u_wf.r_mem[3][0] = ~u_wf.r_mem[3][0];
    do_read(4'h3);
    checks++;
    if (c_rf_v !== 1'b1 || c_rf_p !== 1'b1 || c_rf_d !== 32'h5555_5554 || c_wf_v !== 1'b1 || c_wf_p !== 1'b1) begin
      errors++;
      $display("FAIL parity_err rf=%b/%b/%h wf=%b/%b exp 1/1/55555554 1/1", c_rf_v, c_rf_p, c_rf_d, c_wf_v, c_wf_p);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_clear_read;
    test_full_write;
    test_byte_enable;
    test_write_modes;
    test_reset_mid_clear;
`ifdef SPRAM_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
